rf_param: RTL and testbench



---
 rtl/rf_param.sv | 148 ++++++++++++++
 tb/tb_rf_param.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/rf_param.sv
// Parameterised two-write, two-read register file with optional hard-wired zero
// entry, write-to-read forwarding, sequential clear engine and a registered commit trace.
module rf_param #(
    parameter int unsigned DW       = 32,
    parameter int unsigned AW       = 5,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [AW-1:0]     ra1,
    input  logic [AW-1:0]     ra2,
    output logic [DW-1:0]     rd1,
    output logic [DW-1:0]     rd2,
    input  logic              we0,
    input  logic [AW-1:0]     wa0,
    input  logic [DW-1:0]     wd0,
    input  logic              we1,
    input  logic [AW-1:0]     wa1,
    input  logic [DW-1:0]     wd1,
    input  logic [31:0]       pc8_0,
    input  logic [31:0]       pc8_1,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic [1:0]        trace_valid,
    output logic [2*AW-1:0]   trace_addr,
    output logic [2*DW-1:0]   trace_data,
    output logic [63:0]       trace_pc
);

    localparam int unsigned DEPTH    = 2 ** AW;
    localparam logic [AW:0] LAST_IDX = (AW + 1)'(DEPTH - 1);
    localparam logic [AW:0] IDX_ONE  = (AW + 1)'(1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [AW:0]   idx;
    logic [AW:0]   idx_next;
    logic          in_idle;
    logic          wr_en0;
    logic          wr_en1;
    logic [DW-1:0] mem [DEPTH];

    // ---------------------------------------------------------------- FSM
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; combinational blocks use blocking (=).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            idx   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        case (state)
            ST_IDLE: begin
                if (clr_req) begin
                    state_next = ST_CLEAR;
                    idx_next   = '0;
                end
            end
            ST_CLEAR: begin
                if (idx == LAST_IDX) begin
                    state_next = ST_IDLE;
                    idx_next   = '0;
                end else begin
                    idx_next = idx + IDX_ONE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                idx_next   = '0;
            end
        endcase
    end

    always_comb begin
        in_idle  = (state == ST_IDLE);
        clr_busy = (state == ST_CLEAR);
    end

    // ---------------------------------------------------------------- writes
    // Writes are only accepted while idle; entry 0 is read-only when hard-wired to zero.
    assign wr_en0 = we0 && in_idle && (!ZERO_REG || (wa0 != '0));
    assign wr_en1 = we1 && in_idle && (!ZERO_REG || (wa1 != '0));

    // NOTE: the storage array is reset because every entry must read zero during reset;
    // this forces flip-flops rather than a RAM macro.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clr_busy) begin
            mem[idx[AW-1:0]] <= '0;
        end else begin
            if (wr_en0) mem[wa0] <= wd0;
            // Port 1 is assigned last so it wins a same-address collision.
            if (wr_en1) mem[wa1] <= wd1;
        end
    end

    // ---------------------------------------------------------------- reads
    always_comb begin
        rd1 = mem[ra1];
        if (BYPASS && wr_en0 && (wa0 == ra1)) rd1 = wd0;
        if (BYPASS && wr_en1 && (wa1 == ra1)) rd1 = wd1;
        if (ZERO_REG && (ra1 == '0))          rd1 = '0;
    end

    always_comb begin
        rd2 = mem[ra2];
        if (BYPASS && wr_en0 && (wa0 == ra2)) rd2 = wd0;
        if (BYPASS && wr_en1 && (wa1 == ra2)) rd2 = wd1;
        if (ZERO_REG && (ra2 == '0))          rd2 = '0;
    end

    // ---------------------------------------------------------------- trace
    // Payload slices are forced to zero whenever their strobe is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            trace_valid <= '0;
            trace_addr  <= '0;
            trace_data  <= '0;
            trace_pc    <= '0;
        end else begin
            trace_valid          <= {wr_en1, wr_en0};
            trace_addr[AW-1:0]   <= wr_en0 ? wa0 : '0;
            trace_addr[2*AW-1:AW] <= wr_en1 ? wa1 : '0;
            trace_data[DW-1:0]   <= wr_en0 ? wd0 : '0;
            trace_data[2*DW-1:DW] <= wr_en1 ? wd1 : '0;
            trace_pc[31:0]       <= wr_en0 ? (pc8_0 - 32'd8) : '0;
            trace_pc[63:32]      <= wr_en1 ? (pc8_1 - 32'd8) : '0;
        end
    end

endmodule

// File: tb/tb_rf_param.sv
// Directed bench for rf_param: default instance plus a ZERO_REG=0 / BYPASS=0 instance
// sharing the same stimulus, with table vectors and hand-written clear/reset sequences.
`timescale 1ns/100ps
module tb_rf_param;

    logic        clk;
    logic        reset;
    logic [4:0]  ra1, ra2, wa0, wa1;
    logic [31:0] wd0, wd1, pc8_0, pc8_1;
    logic        we0, we1, clr_req;

    logic [31:0] rd1, rd2, nz_rd1, nz_rd2;
    logic        clr_busy, nz_clr_busy;
    logic [1:0]  trace_valid, nz_trace_valid;
    logic [9:0]  trace_addr, nz_trace_addr;
    logic [63:0] trace_data, nz_trace_data, trace_pc, nz_trace_pc;

    int passed = 0;
    int total  = 0;

    rf_param dut (
        .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .pc8_0(pc8_0), .pc8_1(pc8_1), .clr_req(clr_req), .clr_busy(clr_busy),
        .trace_valid(trace_valid), .trace_addr(trace_addr),
        .trace_data(trace_data), .trace_pc(trace_pc)
    );

    rf_param #(.ZERO_REG(1'b0), .BYPASS(1'b0)) dut_nz (
        .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .rd1(nz_rd1), .rd2(nz_rd2),
        .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
        .pc8_0(pc8_0), .pc8_1(pc8_1), .clr_req(clr_req), .clr_busy(nz_clr_busy),
        .trace_valid(nz_trace_valid), .trace_addr(nz_trace_addr),
        .trace_data(nz_trace_data), .trace_pc(nz_trace_pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        we0;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [31:0] pc0;
        logic        we1;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic [31:0] pc1;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] nz_rd1;
        logic [1:0]  tv;
        logic [9:0]  ta;
        logic [63:0] td;
        logic [63:0] tp;
        logic [1:0]  nz_tv;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else passed++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        we0 = 1'b0; wa0 = '0; wd0 = '0; pc8_0 = '0;
        we1 = 1'b0; wa1 = '0; wd1 = '0; pc8_1 = '0;
        clr_req = 1'b0;
    endtask

    initial begin
        int cnt;
        int errs;

        vecs[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 32'h3008, 1'b0, 5'd0, 32'h0, 32'h0,
                    5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 32'h0,
                    2'b01, 10'd5, {32'h0, 32'hDEADBEEF}, {32'h0, 32'h3000}, 2'b01};
        vecs[1] = '{1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0,
                    5'd5, 5'd7, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF,
                    2'b00, 10'd0, 64'h0, 64'h0, 2'b00};
        vecs[2] = '{1'b1, 5'd7, 32'h11, 32'h100, 1'b1, 5'd7, 32'h22, 32'h200,
                    5'd7, 5'd7, 32'h22, 32'h22, 32'h0,
                    2'b11, {5'd7, 5'd7}, {32'h22, 32'h11}, {32'h1F8, 32'hF8}, 2'b11};
        vecs[3] = '{1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0,
                    5'd7, 5'd5, 32'h22, 32'hDEADBEEF, 32'h22,
                    2'b00, 10'd0, 64'h0, 64'h0, 2'b00};
        vecs[4] = '{1'b1, 5'd0, 32'hFFFFFFFF, 32'h8, 1'b1, 5'd3, 32'hAAAA5555, 32'h4,
                    5'd0, 5'd3, 32'h0, 32'hAAAA5555, 32'h0,
                    2'b10, {5'd3, 5'd0}, {32'hAAAA5555, 32'h0}, {32'hFFFFFFFC, 32'h0}, 2'b11};
        vecs[5] = '{1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0,
                    5'd0, 5'd3, 32'h0, 32'hAAAA5555, 32'hFFFFFFFF,
                    2'b00, 10'd0, 64'h0, 64'h0, 2'b00};
        vecs[6] = '{1'b1, 5'd9, 32'h12345678, 32'h10, 1'b1, 5'd10, 32'hCAFEF00D, 32'h20,
                    5'd10, 5'd9, 32'hCAFEF00D, 32'h12345678, 32'h0,
                    2'b11, {5'd10, 5'd9}, {32'hCAFEF00D, 32'h12345678}, {32'h18, 32'h8}, 2'b11};
        vecs[7] = '{1'b1, 5'd9, 32'h0BADC0DE, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0,
                    5'd9, 5'd10, 32'h0BADC0DE, 32'hCAFEF00D, 32'h12345678,
                    2'b01, {5'd0, 5'd9}, {32'h0, 32'h0BADC0DE}, {32'h0, 32'hFFFFFFF8}, 2'b01};

        // Reset state
        idle_inputs();
        ra1 = 5'd5; ra2 = 5'd7;
        reset = 1'b0;
        #12;
        check("rst_clr_busy", {63'h0, clr_busy}, 64'h0);
        check("rst_trace_valid", {62'h0, trace_valid}, 64'h0);
        check("rst_trace_pc", trace_pc, 64'h0);
        check("rst_rd1", {32'h0, rd1}, 64'h0);
        #10 reset = 1'b1;

        // Table vectors; the first write lands on the first edge after release
        for (int i = 0; i < 8; i++) begin
            we0 = vecs[i].we0; wa0 = vecs[i].wa0; wd0 = vecs[i].wd0; pc8_0 = vecs[i].pc0;
            we1 = vecs[i].we1; wa1 = vecs[i].wa1; wd1 = vecs[i].wd1; pc8_1 = vecs[i].pc1;
            ra1 = vecs[i].ra1; ra2 = vecs[i].ra2;
            #1;
            check($sformatf("v%0d_rd1", i), {32'h0, rd1}, {32'h0, vecs[i].rd1});
            check($sformatf("v%0d_rd2", i), {32'h0, rd2}, {32'h0, vecs[i].rd2});
            check($sformatf("v%0d_nz_rd1", i), {32'h0, nz_rd1}, {32'h0, vecs[i].nz_rd1});
            tick();
            idle_inputs();
            check($sformatf("v%0d_tv", i), {62'h0, trace_valid}, {62'h0, vecs[i].tv});
            check($sformatf("v%0d_ta", i), {54'h0, trace_addr}, {54'h0, vecs[i].ta});
            check($sformatf("v%0d_td", i), trace_data, vecs[i].td);
            check($sformatf("v%0d_tp", i), trace_pc, vecs[i].tp);
            check($sformatf("v%0d_nz_tv", i), {62'h0, nz_trace_valid}, {62'h0, vecs[i].nz_tv});
        end

        // Fill every entry
        for (int i = 0; i < 16; i++) begin
            we0 = 1'b1; wa0 = 5'(2 * i);     wd0 = 32'h1000 + 32'(2 * i);
            we1 = 1'b1; wa1 = 5'(2 * i + 1); wd1 = 32'h1000 + 32'(2 * i + 1);
            tick();
        end
        idle_inputs();
        ra1 = 5'd31; ra2 = 5'd0;
        #1;
        check("fill_rd1_e31", {32'h0, rd1}, 64'h101F);
        check("fill_rd2_e0", {32'h0, rd2}, 64'h0);

        // Clear request together with a write: the write commits, clearing follows
        clr_req = 1'b1; we0 = 1'b1; wa0 = 5'd4; wd0 = 32'h4444;
        tick();
        idle_inputs();
        check("clr_start_busy", {63'h0, clr_busy}, 64'h1);
        check("clr_start_trace", {62'h0, trace_valid}, 64'h1);
        check("clr_start_taddr", {54'h0, trace_addr}, 64'h4);

        cnt = 0;
        while (clr_busy && cnt < 100) begin
            if (cnt == 1) begin
                we0 = 1'b1; wa0 = 5'd20; wd0 = 32'h5555; ra1 = 5'd20;
                clr_req = 1'b1;
                #1;
                check("clr_read_no_bypass", {32'h0, rd1}, 64'h1014);
            end
            tick();
            idle_inputs();
            cnt++;
            if (cnt == 2) check("clr_write_dropped", {62'h0, trace_valid}, 64'h0);
        end
        check("clr_busy_cycles", 64'(cnt), 64'd32);

        errs = 0;
        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i);
            #1;
            if (rd1 !== 32'h0) errs++;
        end
        check("clr_all_zero", 64'(errs), 64'd0);

        // Reset pulse in the middle of a clear
        we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h33;
        tick();
        clr_req = 1'b1; we0 = 1'b0; we1 = 1'b1; wa1 = 5'd30; wd1 = 32'h3030;
        tick();
        idle_inputs();
        check("rstmid_trace_before", {62'h0, trace_valid}, 64'h2);
        tick();
        tick();
        ra1 = 5'd30; ra2 = 5'd3;
        #1;
        check("rstmid_busy_before", {63'h0, clr_busy}, 64'h1);
        check("rstmid_e3_before", {32'h0, rd2}, 64'h33);
        reset = 1'b0;
        #0.5;
        check("rstmid_busy", {63'h0, clr_busy}, 64'h0);
        check("rstmid_trace", {62'h0, trace_valid}, 64'h0);
        check("rstmid_e30", {32'h0, rd1}, 64'h0);
        check("rstmid_e3", {32'h0, rd2}, 64'h0);
        #0.5;
        reset = 1'b1;
        tick();
        check("rstmid_idle_after", {63'h0, clr_busy}, 64'h0);
        we0 = 1'b1; wa0 = 5'd6; wd0 = 32'h66; pc8_0 = 32'h8;
        tick();
        idle_inputs();
        ra1 = 5'd6;
        #1;
        check("rstmid_write_after", {32'h0, rd1}, 64'h66);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got no summary expected completion");
        $fatal(1, "timeout");
    end

endmodule
